// File: rtl/reservoir_pkg.sv
// Shared types for the reservoir sequencer: FSM states, the node tag carried
// alongside the reservoir latency, and saturation limits for signed data.
package reservoir_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      INJECT,
      DRAIN,
      DONE
   } reservoir_ctrl_state_t;

   // Tag node field is sized for the default 10-node reservoir
   localparam int TAG_NODE_W = 4;

   typedef struct packed {
      logic                  valid;
      logic [TAG_NODE_W-1:0] node;
      logic                  last;
   } reservoir_tag_t;

   localparam int TAG_W = $bits(reservoir_tag_t);

   function automatic logic [63:0] dataMax(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] dataMin(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/reservoir_tag_pipe.sv
// Delay line that carries node tags in step with the reservoir latency so each
// reservoir response can be labelled with the node that produced it.
module reservoir_tag_pipe
   import reservoir_pkg::*;
#(
   parameter int DEPTH = 1
)
(
   input  logic             clk,
   input  logic             clr_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o,
   output logic             empty_o
);

   reservoir_tag_t stageQ [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) stageQ[i] <= '0;
      end else begin
         stageQ[0] <= reservoir_tag_t'(tag_i);
         for (int i = 1; i < DEPTH; i++) stageQ[i] <= stageQ[i-1];
      end
   end

   assign tag_o = stageQ[DEPTH-1];

   always_comb begin
      empty_o = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (stageQ[i].valid) empty_o = 1'b0;
      end
   end

endmodule

// File: rtl/reservoir_ctrl.sv
// Sequencer feeding a time-multiplexed reservoir one virtual node per clock.
// Define RESERVOIR_CTRL_MASK_EN to enable the per-node +/- input mask.
module reservoir_ctrl
   import reservoir_pkg::*;
#(
   parameter int VIRTUAL_NODES = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int RES_LATENCY   = 1,
   parameter int CNT_WIDTH     = 16
)
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [CNT_WIDTH-1:0]             num_samples,
   output logic                             busy,
   output logic                             done,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             mask_wr,
   input  logic [VIRTUAL_NODES-1:0]         mask_data,
   output logic [DATA_WIDTH-1:0]            res_din,
   input  logic [DATA_WIDTH-1:0]            res_dout,
   output logic [DATA_WIDTH-1:0]            state_data,
   output logic [$clog2(VIRTUAL_NODES)-1:0] state_node,
   output logic                             state_valid,
   output logic                             state_last
);

   localparam int NODE_W = $clog2(VIRTUAL_NODES);
   localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(VIRTUAL_NODES - 1);

   reservoir_ctrl_state_t stateQ, stateD;
   logic [NODE_W-1:0]     nodeCntQ, nodeCntD;
   logic [CNT_WIDTH-1:0]  sampleCntQ, sampleCntD;
   logic [CNT_WIDTH-1:0]  numSamplesQ, numSamplesD;
   logic [DATA_WIDTH-1:0] sampleQ, sampleD;
   logic [DATA_WIDTH-1:0] nodeValue;
   logic                  lastNode, moreSamples;

   reservoir_tag_t        tagIn, tagOut;
   logic [TAG_W-1:0]      tagOutBits;
   logic                  pipeEmpty;

   logic [DATA_WIDTH-1:0] stateDataQ;
   logic [NODE_W-1:0]     stateNodeQ;
   logic                  stateValidQ, stateLastQ;

`ifdef RESERVOIR_CTRL_MASK_EN
   localparam logic [DATA_WIDTH-1:0] DATA_MAX = DATA_WIDTH'(dataMax(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] DATA_MIN = DATA_WIDTH'(dataMin(DATA_WIDTH));

   logic [VIRTUAL_NODES-1:0] maskQ;

   always_ff @(posedge clk) begin
      if (rst) begin
         maskQ <= '1;
      end else if (stateQ == IDLE && mask_wr) begin
         maskQ <= mask_data;
      end
   end

   // Negating the most-negative value would wrap, so it saturates instead
   always_comb begin
      nodeValue = sampleQ;
      if (!maskQ[nodeCntQ]) begin
         nodeValue = (sampleQ == DATA_MIN) ? DATA_MAX : -sampleQ;
      end
   end
`else
   logic unusedMask;
   assign unusedMask = ^{mask_wr, mask_data};
   assign nodeValue  = sampleQ;
`endif

   assign lastNode    = (nodeCntQ == LAST_NODE);
   assign moreSamples = (sampleCntQ + CNT_WIDTH'(1)) < numSamplesQ;
   assign busy        = (stateQ != IDLE);
   assign done        = (stateQ == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ      <= IDLE;
         nodeCntQ    <= '0;
         sampleCntQ  <= '0;
         numSamplesQ <= '0;
         sampleQ     <= '0;
      end else begin
         stateQ      <= stateD;
         nodeCntQ    <= nodeCntD;
         sampleCntQ  <= sampleCntD;
         numSamplesQ <= numSamplesD;
         sampleQ     <= sampleD;
      end
   end

   always_comb begin
      stateD      = stateQ;
      nodeCntD    = nodeCntQ;
      sampleCntD  = sampleCntQ;
      numSamplesD = numSamplesQ;
      sampleD     = sampleQ;
      in_ready    = 1'b0;
      res_din     = '0;
      tagIn       = '0;
      case (stateQ)
         IDLE: begin
            if (start) begin
               numSamplesD = num_samples;
               sampleCntD  = '0;
               stateD      = (num_samples == '0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sampleD  = in_data;
               nodeCntD = '0;
               stateD   = INJECT;
            end
         end
         INJECT: begin
            res_din      = nodeValue;
            tagIn.valid  = 1'b1;
            tagIn.node   = TAG_NODE_W'(nodeCntQ);
            tagIn.last   = lastNode;
            nodeCntD     = nodeCntQ + NODE_W'(1);
            // The last node overlaps the next handshake so streaming is gapless
            if (lastNode) begin
               nodeCntD   = '0;
               sampleCntD = sampleCntQ + CNT_WIDTH'(1);
               if (moreSamples) begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     sampleD = in_data;
                  end else begin
                     stateD = WAIT;
                  end
               end else begin
                  stateD = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pipeEmpty) stateD = DONE;
         end
         DONE: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   reservoir_tag_pipe #(
      .DEPTH (RES_LATENCY)
   ) tagPipe (
      .clk     (clk),
      .clr_i   (rst),
      .tag_i   (tagIn),
      .tag_o   (tagOutBits),
      .empty_o (pipeEmpty)
   );

   assign tagOut = reservoir_tag_t'(tagOutBits);

   // A tag leaving the delay line lines up with the reservoir's response
   always_ff @(posedge clk) begin
      if (rst) begin
         stateDataQ  <= '0;
         stateNodeQ  <= '0;
         stateValidQ <= 1'b0;
         stateLastQ  <= 1'b0;
      end else begin
         stateValidQ <= tagOut.valid;
         stateLastQ  <= tagOut.valid & tagOut.last;
         if (tagOut.valid) begin
            stateDataQ <= res_dout;
            stateNodeQ <= NODE_W'(tagOut.node);
         end
      end
   end

   assign state_data  = stateDataQ;
   assign state_node  = stateNodeQ;
   assign state_valid = stateValidQ;
   assign state_last  = stateLastQ;

endmodule
